// File: rtl/left_shift_serial.sv
// Serial logical left shifter: one bit per cycle, tracks whether any 1 left the MSB.
// Handshaked in/out, at most one request in flight.
module left_shift_serial #(
   parameter int WIDTH = 4,
   parameter int SHW   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   k,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             lost
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             lost_q, lost_d;
   logic [SHW-1:0]   cnt_q, cnt_d;

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      lost_d    = lost_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d  = in_data;
               lost_d  = 1'b0;
               cnt_d   = k;
               state_d = (k == '0) ? StDone : StShift;
            end
         end
         StShift: begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
            lost_d = lost_q | data_q[WIDTH-1];
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         lost_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         lost_q  <= lost_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data = data_q;
   assign lost     = lost_q;

endmodule

// File: tb/tb_left_shift_serial.sv
// Self-checking bench for left_shift_serial: directed literal cases plus randomized traffic
// checked every cycle against a timestamp-based transaction model.
module tb_left_shift_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [1:0] k;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       lost;

   int n_cmp  = 0;
   int n_fail = 0;

   left_shift_serial #(.WIDTH(4), .SHW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .k         (k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .lost      (lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a pending request becomes visible as a result from edge index m_due onward.
   int         cyc = 0;
   bit         m_pend = 1'b0;
   int         m_due = 0;
   logic [3:0] m_data;
   logic       m_lost;

   always @(posedge clk or negedge rst_n) begin
      logic [7:0] wide;
      bit         vis;
      if (!rst_n) begin
         m_pend = 1'b0;
      end else begin
         vis = m_pend && (cyc >= m_due);
         if (m_pend) begin
            if (vis && out_ready) m_pend = 1'b0;
         end else if (in_valid) begin
            wide   = {4'b0, in_data} << k;
            m_data = wide[3:0];
            m_lost = |wide[7:4];
            m_pend = 1'b1;
            m_due  = cyc + 1 + int'(k);
         end
      end
      if (clk) cyc = cyc + 1;
   end

   always @(negedge clk) begin
      bit ev;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_lost", lost, 0);
      end else begin
         ev = m_pend && (cyc >= m_due);
         chk("in_ready", in_ready, !m_pend);
         chk("out_valid", out_valid, ev);
         if (ev) begin
            chk("out_data", out_data, m_data);
            chk("lost", lost, m_lost);
         end
      end
   end

   // Called just after a rising edge with the block idle.
   task automatic directed(input logic [3:0] d, input logic [1:0] kk, input logic [3:0] ed,
                           input logic el, input int hold);
      int lat;
      chk("pre_ready", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = d;
      k         = kk;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      k        = 2'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      chk("latency", lat, int'(kk) + 1);
      chk("dir_data", out_data, ed);
      chk("dir_lost", lost, el);
      repeat (hold) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = 4'($urandom);
         k        = 2'($urandom);
         @(negedge clk);
         chk("hold_ready", in_ready, 0);
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, ed);
         chk("hold_lost", lost, el);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("post_ready", in_ready, 1);
      chk("post_valid", out_valid, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      k         = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      directed(4'b1011, 2'd1, 4'b0110, 1'b1, 0);
      directed(4'b1001, 2'd0, 4'b1001, 1'b0, 0);
      directed(4'b0001, 2'd3, 4'b1000, 1'b0, 0);
      directed(4'b1111, 2'd3, 4'b1000, 1'b1, 0);
      directed(4'b0011, 2'd2, 4'b1100, 1'b0, 5);

      // Abort during the second shift cycle of a k=3 request.
      in_valid = 1'b1;
      in_data  = 4'b1111;
      k        = 2'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_data", out_data, 0);
      chk("abort_lost", lost, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", in_ready, 1);
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
      end
      @(posedge clk);
      #1;
      directed(4'b0101, 2'd1, 4'b1010, 1'b0, 0);

      repeat (3000) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 4'($urandom);
         k         = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
